// File: rtl/ds1620_pkg.sv
// rtl/ds1620_pkg.sv - shared constants and state types for the DS1620 scheduler
package ds1620_pkg;

    localparam logic [7:0] CMD_WRITE_CONFIG  = 8'h0C;
    localparam logic [7:0] CMD_START_CONVERT = 8'hEE;
    localparam logic [7:0] CMD_READ_CONFIG   = 8'hAC;
    localparam logic [7:0] CMD_READ_TEMP     = 8'hAA;
    localparam logic [7:0] CFG_VALUE         = 8'h03;
    localparam int         DONE_BIT          = 7;

    typedef enum logic [2:0] {
        INIT_CFG,
        IDLE,
        CONV,
        POLL,
        READ_T,
        GAP
    } sched_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_LEAD,
        PH_BITS,
        PH_TAIL
    } shift_phase_t;

endpackage

// File: rtl/ds1620_shifter.sv
// rtl/ds1620_shifter.sv - three-wire serial framing: command, optional write byte, optional read bits
module ds1620_shifter
    import ds1620_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd,
    input  logic [7:0] wr_data,
    input  logic [3:0] n_wr,
    input  logic [3:0] n_rd,
    input  logic       go,
    input  logic       dq_in,
    output logic [8:0] rd_data,
    output logic       done,
    output logic       sclk,
    output logic       xact_en,
    output logic       dq_out,
    output logic       dq_oe
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    shift_phase_t  phase, phase_next;
    logic [CW-1:0] cnt;
    logic [4:0]    bit_idx;
    logic [4:0]    next_idx;
    logic          high_half;
    logic [15:0]   tx_word;
    logic [4:0]    n_out;
    logic [4:0]    n_total;
    logic          half_end;
    logic          last_bit;

    assign half_end = (cnt == CW'(CLK_DIV - 1));
    assign last_bit = (bit_idx == n_total - 5'd1);
    assign next_idx = (phase == PH_LEAD) ? 5'd0 : bit_idx + 5'd1;
    assign done     = (phase == PH_TAIL) && half_end;
    assign xact_en  = (phase != PH_IDLE);

    // Framing phase register; leaving IDLE is what raises the enable line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase <= PH_IDLE;
        else        phase <= phase_next;
    end

    // Phase sequencing: lead-in, bit cells, tail, each measured in half-periods.
    always_comb begin
        phase_next = phase;
        case (phase)
            PH_IDLE: if (go)                               phase_next = PH_LEAD;
            PH_LEAD: if (half_end)                         phase_next = PH_BITS;
            PH_BITS: if (half_end && high_half && last_bit) phase_next = PH_TAIL;
            PH_TAIL: if (half_end)                         phase_next = PH_IDLE;
            default:                                       phase_next = PH_IDLE;
        endcase
    end

    // Bit timing and data path; data only moves on the falling serial-clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_idx   <= '0;
            high_half <= 1'b0;
            tx_word   <= '0;
            n_out     <= '0;
            n_total   <= '0;
            rd_data   <= '0;
            sclk      <= 1'b1;
            dq_out    <= 1'b0;
            dq_oe     <= 1'b0;
        end else begin
            cnt <= (phase == PH_IDLE || half_end) ? '0 : cnt + CW'(1);
            case (phase)
                PH_IDLE: begin
                    sclk <= 1'b1;
                    if (go) begin
                        tx_word   <= {wr_data, cmd};
                        n_out     <= 5'd8 + {1'b0, n_wr};
                        n_total   <= 5'd8 + {1'b0, n_wr} + {1'b0, n_rd};
                        bit_idx   <= '0;
                        high_half <= 1'b0;
                        rd_data   <= '0;
                    end
                end
                PH_LEAD, PH_BITS: begin
                    if (half_end) begin
                        if (phase == PH_BITS && !high_half) begin
                            sclk      <= 1'b1;
                            high_half <= 1'b1;
                            if (bit_idx >= n_out)
                                rd_data <= rd_data | (9'(dq_in) << (bit_idx - n_out));
                        end else if (phase == PH_LEAD || !last_bit) begin
                            sclk      <= 1'b0;
                            high_half <= 1'b0;
                            bit_idx   <= next_idx;
                            if (next_idx < n_out) begin
                                dq_oe  <= 1'b1;
                                dq_out <= tx_word[next_idx[3:0]];
                            end else begin
                                dq_oe  <= 1'b0;
                            end
                        end
                    end
                end
                PH_TAIL: if (half_end) dq_oe <= 1'b0;
                default: sclk <= 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ds1620_scheduler.sv
// rtl/ds1620_scheduler.sv - DS1620 configure/convert/poll/read sequencer
module ds1620_scheduler
    import ds1620_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 100000,
    parameter int MAX_POLLS     = 255
) (
    input  logic       CLK_IN,
    input  logic       CLR_N,
    input  logic       START,
    input  logic       DQ_IN,
    output logic       CLK_OUT,
    output logic       RST,
    output logic       DQ_OUT,
    output logic       TRI_EN,
    output logic [8:0] TEMP,
    output logic       TEMP_VALID,
    output logic       BUSY,
    output logic       ERR
);

    sched_state_t state, state_next, gap_next;
    logic         issued;
    logic         go;
    logic         xact_done;
    logic [7:0]   sh_cmd, sh_wr;
    logic [3:0]   sh_nwr, sh_nrd;
    logic [8:0]   rd_data;
    logic [15:0]  gap_cnt;
    logic         gap_end;
    logic [15:0]  poll_cnt;
    logic [31:0]  timer;
    logic         tick;
    logic         req;
    logic         pending;
    logic         conv_entry;
    logic         poll_ready;
    logic         poll_timeout;

    assign gap_end      = (gap_cnt == 16'(2 * CLK_DIV - 1));
    assign tick         = (SAMPLE_PERIOD != 0) && (timer == 32'(SAMPLE_PERIOD - 1));
    assign req          = START || tick;
    assign conv_entry   = (state_next == CONV) && (state != CONV);
    assign poll_ready   = rd_data[DONE_BIT];
    assign poll_timeout = !poll_ready && ((poll_cnt + 16'd1) >= 16'(MAX_POLLS));
    assign go           = !issued && (state == INIT_CFG || state == CONV ||
                                      state == POLL || state == READ_T);
    assign BUSY         = (state != IDLE);

    ds1620_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk     (CLK_IN),
        .rst_n   (CLR_N),
        .cmd     (sh_cmd),
        .wr_data (sh_wr),
        .n_wr    (sh_nwr),
        .n_rd    (sh_nrd),
        .go      (go),
        .dq_in   (DQ_IN),
        .rd_data (rd_data),
        .done    (xact_done),
        .sclk    (CLK_OUT),
        .xact_en (RST),
        .dq_out  (DQ_OUT),
        .dq_oe   (TRI_EN)
    );

    // Sequencer state register; reset always lands in the configuration write.
    always_ff @(posedge CLK_IN or negedge CLR_N) begin
        if (!CLR_N) state <= INIT_CFG;
        else        state <= state_next;
    end

    // Transaction contents per state, next-state, and pending-request hand-off at GAP exit.
    always_comb begin
        sh_cmd     = CMD_START_CONVERT;
        sh_wr      = 8'h00;
        sh_nwr     = 4'd0;
        sh_nrd     = 4'd0;
        state_next = state;
        case (state)
            INIT_CFG: begin
                sh_cmd = CMD_WRITE_CONFIG;
                sh_wr  = CFG_VALUE;
                sh_nwr = 4'd8;
                if (xact_done) state_next = GAP;
            end
            IDLE:   if (req || pending) state_next = CONV;
            CONV:   if (xact_done) state_next = GAP;
            POLL: begin
                sh_cmd = CMD_READ_CONFIG;
                sh_nrd = 4'd8;
                if (xact_done) state_next = GAP;
            end
            READ_T: begin
                sh_cmd = CMD_READ_TEMP;
                sh_nrd = 4'd9;
                if (xact_done) state_next = GAP;
            end
            GAP: begin
                if (gap_end) begin
                    if (gap_next == IDLE && (req || pending)) state_next = CONV;
                    else                                       state_next = gap_next;
                end
            end
            default: state_next = INIT_CFG;
        endcase
    end

    // Bookkeeping: issue-once flag, gap timing, poll counting, timer, pending, results.
    always_ff @(posedge CLK_IN or negedge CLR_N) begin
        if (!CLR_N) begin
            issued     <= 1'b0;
            gap_cnt    <= '0;
            gap_next   <= IDLE;
            poll_cnt   <= '0;
            timer      <= '0;
            pending    <= 1'b0;
            TEMP       <= '0;
            TEMP_VALID <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            if (xact_done)  issued <= 1'b0;
            else if (go)    issued <= 1'b1;

            gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : '0;

            if (conv_entry || tick)        timer <= '0;
            else if (SAMPLE_PERIOD != 0)   timer <= timer + 32'd1;

            if (conv_entry)                pending <= 1'b0;
            else if (req && state != IDLE) pending <= 1'b1;

            if (conv_entry) poll_cnt <= '0;

            TEMP_VALID <= 1'b0;
            if (xact_done) begin
                case (state)
                    CONV:   gap_next <= POLL;
                    POLL: begin
                        poll_cnt <= poll_cnt + 16'd1;
                        if (poll_ready) begin
                            gap_next <= READ_T;
                        end else if (poll_timeout) begin
                            gap_next <= IDLE;
                            ERR      <= 1'b1;
                        end else begin
                            gap_next <= POLL;
                        end
                    end
                    READ_T: begin
                        gap_next   <= IDLE;
                        TEMP       <= rd_data;
                        TEMP_VALID <= 1'b1;
                        ERR        <= 1'b0;
                    end
                    default: gap_next <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ds1620_scheduler.sv
// tb/tb_ds1620_scheduler.sv - scoreboard bench for ds1620_scheduler with a behavioural sensor
module tb_ds1620_scheduler;

    logic       CLK_IN = 1'b0;
    logic       CLR_N  = 1'b1;
    logic       START  = 1'b0;
    logic       DQ_IN  = 1'b0;
    logic       CLK_OUT, RST, DQ_OUT, TRI_EN, TEMP_VALID, BUSY, ERR;
    logic [8:0] TEMP;

    logic       p_clr_n = 1'b1;
    logic       p_clk_out, p_rst, p_dq_out, p_tri_en, p_temp_valid, p_busy, p_err;
    logic [8:0] p_temp;

    always #5 CLK_IN = ~CLK_IN;

    ds1620_scheduler #(.CLK_DIV(2), .SAMPLE_PERIOD(0), .MAX_POLLS(4)) dut (
        .CLK_IN(CLK_IN), .CLR_N(CLR_N), .START(START), .DQ_IN(DQ_IN),
        .CLK_OUT(CLK_OUT), .RST(RST), .DQ_OUT(DQ_OUT), .TRI_EN(TRI_EN),
        .TEMP(TEMP), .TEMP_VALID(TEMP_VALID), .BUSY(BUSY), .ERR(ERR)
    );

    ds1620_scheduler #(.CLK_DIV(2), .SAMPLE_PERIOD(500), .MAX_POLLS(4)) dut_p (
        .CLK_IN(CLK_IN), .CLR_N(p_clr_n), .START(1'b0), .DQ_IN(1'b1),
        .CLK_OUT(p_clk_out), .RST(p_rst), .DQ_OUT(p_dq_out), .TRI_EN(p_tri_en),
        .TEMP(p_temp), .TEMP_VALID(p_temp_valid), .BUSY(p_busy), .ERR(p_err)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // sensor model state
    int          bit_n = 0;
    logic [7:0]  cmd_sh = '0;
    logic [15:0] wbits = '0;
    logic [8:0]  rd_word = '0;
    int          poll_num = 0;
    int          done_at = 1;
    logic [8:0]  temp_val = '0;

    // transaction log
    int          n_xact = 0, n_ac = 0, n_ee = 0, n_aa_seen = 0, oe_err = 0;
    logic [7:0]  last_cmd = '0;
    int          last_nbits = 0;
    logic [15:0] last_wbits = '0;
    int          rst_fall_cyc = 0;
    int          busy_fall_cyc = 0, n_busy_fall = 0, tv_count = 0;
    logic        busy_prev = 1'b1, p_busy_prev = 1'b1;

    logic [8:0]  exp_q[$];
    logic [8:0]  got_q[$];
    int          rise_q[$];

    always @(posedge CLK_IN) cyc++;

    always @(posedge RST) begin
        bit_n = 0; cmd_sh = '0; wbits = '0;
    end

    always @(posedge CLK_OUT) if (RST === 1'b1) begin
        if (bit_n < 8 || cmd_sh == 8'h0C) begin
            if (TRI_EN !== 1'b1) oe_err++;
            if (bit_n < 16) wbits[bit_n] = DQ_OUT;
            if (bit_n < 8)  cmd_sh[bit_n] = DQ_OUT;
        end else if (TRI_EN !== 1'b0) begin
            oe_err++;
        end
        bit_n++;
        if (bit_n == 8) begin
            if (cmd_sh == 8'hEE) poll_num = 0;
            if (cmd_sh == 8'hAC) begin
                poll_num++;
                rd_word = {1'b0, (poll_num >= done_at), 7'h03};
            end
            if (cmd_sh == 8'hAA) begin
                rd_word = temp_val;
                n_aa_seen++;
            end
        end
    end

    always @(negedge CLK_OUT)
        if (RST === 1'b1 && bit_n >= 8 && bit_n < 17) DQ_IN = rd_word[bit_n - 8];

    always @(negedge RST) begin
        n_xact++;
        last_cmd = cmd_sh; last_nbits = bit_n; last_wbits = wbits;
        if (cmd_sh == 8'hAC) n_ac++;
        if (cmd_sh == 8'hEE) n_ee++;
        rst_fall_cyc = cyc;
    end

    always @(negedge CLK_IN) begin
        if (busy_prev && !BUSY) begin n_busy_fall++; busy_fall_cyc = cyc; end
        busy_prev = BUSY;
        if (TEMP_VALID === 1'b1) begin tv_count++; got_q.push_back(TEMP); end
        if (!p_busy_prev && p_busy) rise_q.push_back(cyc);
        p_busy_prev = p_busy;
    end

    task automatic pulse_start();
        @(posedge CLK_IN); #1 START = 1'b1;
        @(posedge CLK_IN); #1 START = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        @(negedge CLK_IN);
        while (BUSY !== 1'b0 && n < budget) begin @(negedge CLK_IN); n++; end
        if (BUSY !== 1'b0) begin
            vectors++; miscompares++;
            $display("FAIL %s_idle_timeout BUSY=%b want 0", name, BUSY);
        end
        @(posedge CLK_IN); #1;
    endtask

    task automatic wait_xact(input int n0, input int budget, input string name);
        int n = 0;
        while (n_xact == n0 && n < budget) begin @(negedge CLK_IN); n++; end
        if (n_xact == n0) begin
            vectors++; miscompares++;
            $display("FAIL %s_xact_timeout n_xact=%0d want >%0d", name, n_xact, n0);
        end
    endtask

    task automatic test_reset();
        int n0;
        #3;
        vectors++;
        if ({CLK_OUT, RST, DQ_OUT, TRI_EN, TEMP_VALID, BUSY, ERR} !== 7'b1000010) begin
            miscompares++;
            $display("FAIL reset_outputs got %b want 1000010", {CLK_OUT, RST, DQ_OUT, TRI_EN, TEMP_VALID, BUSY, ERR});
        end
        vectors++;
        if (TEMP !== 9'h000) begin miscompares++; $display("FAIL reset_temp got %h want 000", TEMP); end
        repeat (2) @(posedge CLK_IN);
        n0 = n_xact;
        #1 CLR_N = 1'b1;
        wait_xact(n0, 200, "init");
        vectors++;
        if (last_cmd !== 8'h0C) begin miscompares++; $display("FAIL init_cmd got %h want 0C", last_cmd); end
        vectors++;
        if (last_nbits != 16) begin miscompares++; $display("FAIL init_nbits got %0d want 16", last_nbits); end
        vectors++;
        if (last_wbits !== 16'h030C) begin miscompares++; $display("FAIL init_bits got %h want 030C", last_wbits); end
        wait_idle(100, "init");
        vectors++;
        if (busy_fall_cyc - rst_fall_cyc != 4) begin
            miscompares++; $display("FAIL init_gap got %0d want 4", busy_fall_cyc - rst_fall_cyc);
        end
    endtask

    task automatic test_conversion();
        int a0, t0;
        logic [8:0] e, g;
        done_at = 3; temp_val = 9'h032;
        a0 = n_ac; t0 = tv_count; got_q.delete();
        exp_q.push_back(9'h032);
        pulse_start();
        wait_idle(1500, "conv");
        vectors++;
        if (n_ac - a0 != 3) begin miscompares++; $display("FAIL conv_polls got %0d want 3", n_ac - a0); end
        vectors++;
        if (tv_count - t0 != 1) begin miscompares++; $display("FAIL conv_tv got %0d want 1", tv_count - t0); end
        vectors++;
        if (got_q.size() < 1) begin
            miscompares++; $display("FAIL conv_sb_empty got 0 results want 1");
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) begin miscompares++; $display("FAIL conv_temp got %h want %h", g, e); end
        end
        vectors++;
        if (ERR !== 1'b0) begin miscompares++; $display("FAIL conv_err got %b want 0", ERR); end
        vectors++;
        if (busy_fall_cyc - rst_fall_cyc != 4) begin
            miscompares++; $display("FAIL conv_gap got %0d want 4", busy_fall_cyc - rst_fall_cyc);
        end
        vectors++;
        if (oe_err != 0) begin miscompares++; $display("FAIL conv_tri_en got %0d bad bits want 0", oe_err); end
    endtask

    task automatic test_timeout();
        int a0, t0;
        logic [8:0] e, g;
        done_at = 100;
        a0 = n_ac; t0 = tv_count;
        pulse_start();
        wait_idle(1500, "tmo");
        vectors++;
        if (n_ac - a0 != 4) begin miscompares++; $display("FAIL tmo_polls got %0d want 4", n_ac - a0); end
        vectors++;
        if (ERR !== 1'b1) begin miscompares++; $display("FAIL tmo_err got %b want 1", ERR); end
        vectors++;
        if (TEMP !== 9'h032) begin miscompares++; $display("FAIL tmo_temp got %h want 032", TEMP); end
        vectors++;
        if (tv_count != t0) begin miscompares++; $display("FAIL tmo_tv got %0d want 0", tv_count - t0); end
        done_at = 1; temp_val = 9'h1F6; got_q.delete();
        exp_q.push_back(9'h1F6);
        pulse_start();
        wait_idle(1500, "recover");
        vectors++;
        if (ERR !== 1'b0) begin miscompares++; $display("FAIL recover_err got %b want 0", ERR); end
        vectors++;
        if (got_q.size() < 1) begin
            miscompares++; $display("FAIL recover_sb_empty got 0 results want 1");
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) begin miscompares++; $display("FAIL recover_temp got %h want %h", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        int e0, f0, t0;
        logic [8:0] e, g;
        done_at = 1; temp_val = 9'h019;
        e0 = n_ee; f0 = n_busy_fall; t0 = tv_count; got_q.delete();
        exp_q.push_back(9'h019); exp_q.push_back(9'h019);
        pulse_start();
        repeat (30) @(posedge CLK_IN);
        for (int i = 0; i < 3; i++) begin pulse_start(); repeat (5) @(posedge CLK_IN); end
        wait_idle(2000, "b2b");
        vectors++;
        if (n_ee - e0 != 2) begin miscompares++; $display("FAIL b2b_convs got %0d want 2", n_ee - e0); end
        vectors++;
        if (n_busy_fall - f0 != 1) begin miscompares++; $display("FAIL b2b_busy_falls got %0d want 1", n_busy_fall - f0); end
        vectors++;
        if (tv_count - t0 != 2) begin miscompares++; $display("FAIL b2b_tv got %0d want 2", tv_count - t0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_q.size() == 0) begin
                miscompares++; $display("FAIL b2b_sb_missing got none want %h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin miscompares++; $display("FAIL b2b_temp got %h want %h", g, e); end
            end
        end
        repeat (200) @(posedge CLK_IN);
        vectors++;
        if (n_ee - e0 != 2 || BUSY !== 1'b0) begin
            miscompares++; $display("FAIL b2b_quiet got convs=%0d busy=%b want 2 0", n_ee - e0, BUSY);
        end
    endtask

    task automatic test_reset_mid_read();
        int a0, t0, n0, n = 0;
        CLR_N = 1'b0;
        repeat (2) @(posedge CLK_IN);
        n0 = n_xact;
        #1 CLR_N = 1'b1;
        wait_xact(n0, 200, "rr_init");
        wait_idle(100, "rr_init");
        done_at = 1; temp_val = 9'h0AB;
        a0 = n_aa_seen; t0 = tv_count;
        pulse_start();
        while (n_aa_seen == a0 && n < 1000) begin @(negedge CLK_IN); n++; end
        vectors++;
        if (n_aa_seen == a0) begin miscompares++; $display("FAIL rr_no_read got 0 want 1"); end
        repeat (10) @(posedge CLK_IN);
        #3 CLR_N = 1'b0;
        #1;
        vectors++;
        if ({RST, CLK_OUT, TRI_EN, BUSY} !== 4'b0101) begin
            miscompares++; $display("FAIL rr_async got %b want 0101", {RST, CLK_OUT, TRI_EN, BUSY});
        end
        repeat (3) @(posedge CLK_IN);
        #1;
        vectors++;
        if (TEMP !== 9'h000 || tv_count != t0) begin
            miscompares++; $display("FAIL rr_temp got %h tv=%0d want 000 0", TEMP, tv_count - t0);
        end
        n0 = n_xact;
        CLR_N = 1'b1;
        wait_xact(n0, 200, "rr_restart");
        vectors++;
        if (last_cmd !== 8'h0C || last_wbits !== 16'h030C) begin
            miscompares++; $display("FAIL rr_restart got %h/%h want 0C/030C", last_cmd, last_wbits);
        end
        wait_idle(100, "rr_restart");
        vectors++;
        if (TEMP !== 9'h000) begin miscompares++; $display("FAIL rr_temp_after got %h want 000", TEMP); end
    endtask

    task automatic test_period();
        int n = 0;
        @(posedge CLK_IN);
        p_clr_n = 1'b0;
        repeat (2) @(posedge CLK_IN);
        #1 p_clr_n = 1'b1;
        rise_q.delete();
        while (rise_q.size() < 4 && n < 2600) begin @(negedge CLK_IN); n++; end
        vectors++;
        if (rise_q.size() < 4) begin
            miscompares++; $display("FAIL period_starts got %0d want 4", rise_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (rise_q[i] - rise_q[i-1] != 500) begin
                    miscompares++; $display("FAIL period_interval%0d got %0d want 500", i, rise_q[i] - rise_q[i-1]);
                end
            end
        end
    endtask

    initial begin
        #2 CLR_N = 1'b0; p_clr_n = 1'b0;
        test_reset();
        test_conversion();
        test_timeout();
        test_back_to_back();
        test_reset_mid_read();
        test_period();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d want completion", cyc);
        $fatal(1);
    end

endmodule

// File: doc/ds1620_scheduler.md
DS1620_SCHEDULER -- requirements
Module: ds1620_scheduler

Interface
REQ-001 Parameter CLK_DIV, default 4: CLK_IN cycles per half serial-clock period (legal >= 2).
REQ-002 Parameter SAMPLE_PERIOD, default 100000: CLK_IN cycles between automatic conversions (0 = automatic off).
REQ-003 Parameter MAX_POLLS, default 255: status reads allowed before a conversion timeout.
REQ-004 CLK_IN  in  1  single clock, all logic on rising edge.
REQ-005 CLR_N  in  1  asynchronous active-low reset.
REQ-006 START  in  1  one-cycle conversion request.
REQ-007 DQ_IN  in  1  sensor data line, read side.
REQ-008 CLK_OUT  out  1  sensor serial clock, idles high.
REQ-009 RST  out  1  sensor transaction enable, high during a transaction.
REQ-010 DQ_OUT  out  1  sensor data line, drive side.
REQ-011 TRI_EN  out  1  1 = DQ_OUT drives the line; 0 = line released.
REQ-012 TEMP  out  9  last good temperature, two's complement, 0.5 C/LSB.
REQ-013 TEMP_VALID  out  1  one-cycle pulse when TEMP updates.
REQ-014 BUSY  out  1  high whenever the FSM is not in IDLE.
REQ-015 ERR  out  1  sticky conversion timeout; cleared by the next successful read.

Function
REQ-016 FSM states: INIT_CFG, IDLE, CONV, POLL, READ_T, GAP.
REQ-017 After reset the FSM enters INIT_CFG and sends command 0x0C then data 0x03 (CPU=1, 1SHOT=1); it then goes to GAP, then IDLE.
REQ-018 IDLE moves to CONV on START or on period-timer expiry; CONV sends 0xEE.
REQ-019 POLL sends 0xAC and reads 8 bits; bit 7 (DONE) = 1 moves to READ_T; otherwise it passes through GAP and repeats POLL.
REQ-020 Poll count reaching MAX_POLLS with DONE = 0 sets ERR and returns through GAP to IDLE; TEMP is unchanged.
REQ-021 READ_T sends 0xAA and reads 9 bits; in the cycle the transaction ends, TEMP loads and TEMP_VALID pulses.
REQ-022 All bits are LSB first; one bit spans 2*CLK_DIV cycles: CLK_OUT low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-023 Transaction framing: RST rises, CLK_DIV idle cycles follow, then the bits; after the last high phase, CLK_DIV cycles elapse, then RST falls.
REQ-024 Write bits: DQ_OUT changes only at the CLK_OUT falling edge, with TRI_EN = 1.
REQ-025 Read bits: TRI_EN = 0 from the first read-bit falling edge until RST falls; DQ_IN is sampled in the last cycle before CLK_OUT rises.
REQ-026 GAP holds RST = 0 and CLK_OUT = 1 for 2*CLK_DIV cycles between transactions.
REQ-027 START while BUSY sets a single pending flag; further STARTs are absorbed; a pending request is serviced on the next IDLE entry without an idle cycle.
REQ-028 The period timer reloads on every CONV entry; a timer expiry while BUSY counts as pending.
REQ-029 TEMP_VALID and ERR-set cannot occur in the same cycle.

Reset
REQ-030 CLR_N low immediately sets: CLK_OUT = 1, RST = 0, DQ_OUT = 0, TRI_EN = 0, TEMP = 0, TEMP_VALID = 0, BUSY = 1, ERR = 0; pending and all counters clear.
REQ-031 Reset mid-transaction aborts with no TEMP update; release always restarts at INIT_CFG.

Structure
REQ-032 A shared package ds1620_pkg holds command constants (0x0C, 0xEE, 0xAC, 0xAA), CFG_VALUE 0x03, DONE_BIT 7, and the state enum.
REQ-033 One sub-module, ds1620_shifter, does serial framing: inputs cmd, wr_data, n_wr, n_rd, go; outputs rd_data, done. The scheduler owns sequencing, timers and polling.

Verification
REQ-034 Reset with CLK_DIV=2: all outputs at REQ-030 values; after release, DQ_OUT bits 0,0,1,1,0,0,0,0 then 1,1,0,0,0,0,0,0, with RST high across all 16 bits.
REQ-035 START pulse; sensor model reports DONE on the 3rd poll and then TEMP 9'h032: exactly three 0xAC transactions occur, TEMP = 0x032, TEMP_VALID pulses once, BUSY falls after GAP.
REQ-036 MAX_POLLS=4; DONE never set: exactly 4 polls occur, ERR = 1, TEMP unchanged, FSM returns to IDLE; a following good read clears ERR.
REQ-037 Three START pulses during one conversion: exactly one extra conversion runs, immediately after the first.
REQ-038 CLR_N asserted mid-READ_T: RST = 0 in the same cycle, TEMP stays 0, and INIT_CFG runs again after release.
REQ-039 SAMPLE_PERIOD=500 with no START: CONV starts occur every 500 cycles (from CONV entry), checked over 3 periods.
